// File: rtl/decode_pkg.sv
// Shared widths and types for the decode operand stage.
package decode_pkg;
   localparam int XLEN      = 32;
   localparam int REG_COUNT = 32;
   localparam int IDW       = $clog2(REG_COUNT);

   typedef logic [IDW-1:0]  reg_id_t;
   typedef logic [XLEN-1:0] xdata_t;

   // One result producer that a source operand may be taken from.
   typedef struct packed {
      reg_id_t id;
      logic    ready;
      xdata_t  data;
   } fwd_source_t;
endpackage

// File: rtl/operand_forward_mux.sv
// Priority operand select for one read port: first matching producer wins, else register file.
module operand_forward_mux
   import decode_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  reg_id_t                src_id_i,
   input  logic                   src_need_i,
   input  fwd_source_t [NSRC-1:0] cand_i,
   input  xdata_t                 rf_data_i,
   output xdata_t                 operand_o,
   output logic                   hazard_o
);

   logic found;

   // Walk candidates youngest first; an unready match blocks older sources and the register file.
   always_comb begin
      operand_o = rf_data_i;
      hazard_o  = 1'b0;
      found     = 1'b0;
      if (src_id_i == '0) begin
         operand_o = '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (!found && cand_i[i].id == src_id_i) begin
               found = 1'b1;
               if (cand_i[i].ready) begin
                  operand_o = cand_i[i].data;
               end else begin
                  operand_o = '0;
                  hazard_o  = src_need_i;
               end
            end
         end
      end
   end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode-side operand stage: reads sources, forwards/stalls on RAW hazards, registers the result.
module decode_operand_stage
   import decode_pkg::*;
#(
   parameter int READ_PORTS  = 2,
   parameter int FWD_STAGES  = 3,
   parameter int STALL_LIMIT = 15,
   localparam int SCW        = $clog2(STALL_LIMIT+1)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [READ_PORTS*IDW-1:0]  in_src_id,
   input  logic [READ_PORTS-1:0]      in_src_need,
   input  logic [IDW-1:0]             in_wr_id,
   input  logic                       in_wr_ready,
   input  logic [XLEN-1:0]            in_wr_data,
   output logic [READ_PORTS*IDW-1:0]  rf_read_id,
   input  logic [READ_PORTS*XLEN-1:0] rf_read_data,
   input  logic [FWD_STAGES*IDW-1:0]  fwd_id,
   input  logic [FWD_STAGES-1:0]      fwd_ready,
   input  logic [FWD_STAGES*XLEN-1:0] fwd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [READ_PORTS*XLEN-1:0] out_operand,
   output logic [IDW-1:0]             out_wr_id,
   output logic                       out_wr_ready,
   output logic [XLEN-1:0]            out_wr_data,
   output logic                       stall,
   output logic [SCW-1:0]             stall_count,
   output logic                       watchdog
);

   localparam logic [SCW-1:0] LIMIT = SCW'(STALL_LIMIT);

   logic                         valid_q;
   logic [XLEN-1:0]              pc_q;
   logic [READ_PORTS*XLEN-1:0]   operand_q;
   logic [READ_PORTS*XLEN-1:0]   operand_d;
   logic [IDW-1:0]               wr_id_q;
   logic                         wr_ready_q;
   logic [XLEN-1:0]              wr_data_q;
   logic [SCW-1:0]               count_q, count_d;
   logic                         watchdog_q;

   fwd_source_t [FWD_STAGES:0]   cand;
   logic [READ_PORTS-1:0]        port_hazard;
   logic                         hazard, fire;

   assign rf_read_id = in_src_id;

   // Candidate list: own output register first (youngest), then downstream stages in order.
   always_comb begin
      cand[0].id    = valid_q ? wr_id_q : '0;
      cand[0].ready = wr_ready_q;
      cand[0].data  = wr_data_q;
      for (int s = 0; s < FWD_STAGES; s++) begin
         cand[s+1].id    = fwd_id[s*IDW +: IDW];
         cand[s+1].ready = fwd_ready[s];
         cand[s+1].data  = fwd_data[s*XLEN +: XLEN];
      end
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      operand_forward_mux #(.NSRC(FWD_STAGES+1)) u_mux (
         .src_id_i   (in_src_id[p*IDW +: IDW]),
         .src_need_i (in_src_need[p]),
         .cand_i     (cand),
         .rf_data_i  (rf_read_data[p*XLEN +: XLEN]),
         .operand_o  (operand_d[p*XLEN +: XLEN]),
         .hazard_o   (port_hazard[p])
      );
   end

   assign hazard   = |port_hazard;
   assign stall    = in_valid && hazard;
   assign in_ready = !flush && !hazard && (!valid_q || out_ready);
   assign fire     = in_valid && in_ready;

   // Output register: flush beats load, load beats drain, otherwise hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         operand_q  <= '0;
         wr_id_q    <= '0;
         wr_ready_q <= 1'b0;
         wr_data_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (fire) begin
         valid_q    <= 1'b1;
         pc_q       <= in_pc;
         operand_q  <= operand_d;
         wr_id_q    <= in_wr_id;
         wr_ready_q <= in_wr_ready;
         wr_data_q  <= in_wr_data;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Consecutive stall cycles, saturating so the watchdog stays asserted.
   always_comb begin
      count_d = '0;
      if (!flush && !fire && stall)
         count_d = (count_q == LIMIT) ? count_q : count_q + 1'b1;
   end

   // Counter and watchdog registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q    <= '0;
         watchdog_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         watchdog_q <= (count_d == LIMIT);
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_operand  = operand_q;
   assign out_wr_id    = wr_id_q;
   assign out_wr_ready = wr_ready_q;
   assign out_wr_data  = wr_data_q;
   assign stall_count  = count_q;
   assign watchdog     = watchdog_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage with hand-computed expectations.
module tb_decode_operand_stage;
   localparam int XLEN = 32, IDW = 5, RP = 2, FS = 3, SCW = 4;

   logic                clock = 1'b0;
   logic                reset, flush, in_valid, in_ready;
   logic [XLEN-1:0]     in_pc, in_wr_data;
   logic [RP*IDW-1:0]   in_src_id, rf_read_id;
   logic [RP-1:0]       in_src_need;
   logic [IDW-1:0]      in_wr_id, out_wr_id;
   logic                in_wr_ready, out_wr_ready;
   logic [RP*XLEN-1:0]  rf_read_data, out_operand;
   logic [FS*IDW-1:0]   fwd_id;
   logic [FS-1:0]       fwd_ready;
   logic [FS*XLEN-1:0]  fwd_data;
   logic                out_valid, out_ready, stall, watchdog;
   logic [XLEN-1:0]     out_pc, out_wr_data;
   logic [SCW-1:0]      stall_count;

   int errors = 0, checks = 0;

   decode_operand_stage dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_src_id(in_src_id), .in_src_need(in_src_need),
      .in_wr_id(in_wr_id), .in_wr_ready(in_wr_ready), .in_wr_data(in_wr_data),
      .rf_read_id(rf_read_id), .rf_read_data(rf_read_data),
      .fwd_id(fwd_id), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_operand(out_operand), .out_wr_id(out_wr_id),
      .out_wr_ready(out_wr_ready), .out_wr_data(out_wr_data),
      .stall(stall), .stall_count(stall_count), .watchdog(watchdog)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s0,
                        input logic [4:0] wid, input logic wrdy, input logic [31:0] wdat);
      in_valid    = 1'b1;
      in_pc       = pc;
      in_src_id   = {s1, s0};
      in_src_need = 2'b11;
      in_wr_id    = wid;
      in_wr_ready = wrdy;
      in_wr_data  = wdat;
   endtask

   task automatic clr_fwd();
      fwd_id = '0; fwd_ready = '0; fwd_data = '0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_pc = '0; in_src_id = '0; in_src_need = '0; in_wr_id = '0;
      in_wr_ready = 1'b0; in_wr_data = '0; rf_read_data = '0;
      clr_fwd();
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", out_valid, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_opnd", out_operand, 0);
      chk("rst_cnt", stall_count, 0);
      chk("rst_wd", watchdog, 0);

      // independent instruction
      instr(32'h100, 5'd4, 5'd3, 5'd0, 1'b0, 32'h0);
      rf_read_data = {32'd22, 32'd11};
      #1;
      chk("rf_id", rf_read_id, {5'd4, 5'd3});
      chk("ind_stall", stall, 0);
      chk("ind_rdy", in_ready, 1);
      tick();
      chk("ind_valid", out_valid, 1);
      chk("ind_pc", out_pc, 32'h100);
      chk("ind_op0", out_operand[31:0], 11);
      chk("ind_op1", out_operand[63:32], 22);

      // producer with known result, then consumer: own reg beats fwd[1]
      instr(32'h104, 5'd0, 5'd0, 5'd5, 1'b1, 32'hBB);
      tick();
      chk("prod_wrid", out_wr_id, 5);
      instr(32'h108, 5'd0, 5'd5, 5'd0, 1'b0, 32'h0);
      fwd_id = {5'd0, 5'd5, 5'd0}; fwd_ready = 3'b010; fwd_data = {32'h0, 32'hAA, 32'h0};
      #1;
      chk("yw_stall", stall, 0);
      tick();
      chk("yw_op0", out_operand[31:0], 32'hBB);

      // load-use: fwd[0] not ready
      instr(32'h10C, 5'd0, 5'd7, 5'd0, 1'b0, 32'h0);
      fwd_id = {5'd0, 5'd0, 5'd7}; fwd_ready = 3'b000; fwd_data = {64'h0, 32'h77};
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_rdy", in_ready, 0);
      tick();
      chk("lu_cnt1", stall_count, 1);
      chk("lu_drain", out_valid, 0);
      tick();
      chk("lu_cnt2", stall_count, 2);
      fwd_ready = 3'b001;
      #1;
      chk("lu_nostall", stall, 0);
      tick();
      chk("lu_op0", out_operand[31:0], 32'h77);
      chk("lu_pc", out_pc, 32'h10C);
      chk("lu_cnt0", stall_count, 0);

      // long stall: saturation and watchdog
      fwd_ready = 3'b000;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            chk("sat14_cnt", stall_count, 14);
            chk("sat14_wd", watchdog, 0);
         end
         if (i == 15) begin
            chk("sat15_cnt", stall_count, 15);
            chk("sat15_wd", watchdog, 1);
         end
      end
      chk("sat20_cnt", stall_count, 15);
      chk("sat20_wd", watchdog, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_cnt", stall_count, 0);
      chk("fl_wd", watchdog, 0);

      // back-pressure hold
      clr_fwd();
      out_ready = 1'b0;
      instr(32'h200, 5'd2, 5'd1, 5'd0, 1'b0, 32'h0);
      rf_read_data = {32'h44, 32'h33};
      tick();
      chk("bp_valid", out_valid, 1);
      instr(32'h204, 5'd2, 5'd1, 5'd0, 1'b0, 32'h0);
      rf_read_data = {32'h66, 32'h55};
      #1;
      chk("bp_rdy", in_ready, 0);
      tick();
      chk("bp_pc", out_pc, 32'h200);
      chk("bp_op", out_operand, {32'h44, 32'h33});
      chk("bp_hold", out_valid, 1);
      flush = 1'b1;
      tick();
      chk("bp_flush", out_valid, 0);
      chk("bp_flcnt", stall_count, 0);

      // flush with a fire-eligible input drops it
      out_ready = 1'b1;
      instr(32'h300, 5'd2, 5'd1, 5'd0, 1'b0, 32'h0);
      #1;
      chk("fd_rdy", in_ready, 0);
      tick();
      flush = 1'b0;
      chk("fd_valid", out_valid, 0);
      chk("fd_pc", out_pc, 32'h200);

      // register 0 source: zero, never a hazard
      instr(32'h400, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
      rf_read_data = {32'h99, 32'h99};
      fwd_id = '0; fwd_ready = 3'b000;
      #1;
      chk("z_stall", stall, 0);
      tick();
      chk("z_op", out_operand, 0);
      chk("z_valid", out_valid, 1);

      // reset while holding and stalling
      out_ready = 1'b0;
      instr(32'h500, 5'd0, 5'd7, 5'd0, 1'b0, 32'h0);
      fwd_id = {5'd0, 5'd0, 5'd7}; fwd_ready = 3'b000;
      tick(); tick(); tick();
      chk("rs_cnt", stall_count, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("rs_valid", out_valid, 0);
      chk("rs_pc", out_pc, 0);
      chk("rs_cnt0", stall_count, 0);
      chk("rs_wd", watchdog, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
